// File: rtl/chunked_serial_adder_if.sv
// Handshake and operand/result bundle for chunked_serial_adder.
//   master : the controlling FSM (drives start/Sub/A/B/Cin, sees Busy/Done/results)
//   slave  : the adder itself
// Signals:
//   start    request an operation, sampled on the rising clock edge
//   Sub      0 = add, 1 = subtract (A - B)
//   A, B     WIDTH-bit operands
//   Cin      carry-in (add) or borrow-in (subtract)
//   Busy     chunk cycles in progress
//   Done     one-cycle pulse, results valid
//   Sum      WIDTH-bit result
//   Cout     carry out of MSB (add) / not-borrow (subtract)
//   Overflow two's-complement signed overflow
interface chunked_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             Sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Overflow;

  modport master (
    output start, Sub, A, B, Cin,
    input  Busy, Done, Sum, Cout, Overflow
  );

  modport slave (
    input  start, Sub, A, B, Cin,
    output Busy, Done, Sum, Cout, Overflow
  );
endinterface

// File: rtl/chunked_serial_adder.sv
// Multi-cycle add/subtract unit. Each RUN cycle pushes CHUNK bits of the
// latched operands through a CHUNK-bit ripple chain of full adders; the chunk
// carry is kept in a register between cycles. One result every NCH+1 cycles.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-high reset (priority over start)
//   bus  slave side of chunked_serial_adder_if (start/Sub/A/B/Cin in,
//        Busy/Done/Sum/Cout/Overflow out)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start
// RUN   | one chunk per cycle, k = 0 .. NCH-1
// DONE  | one-cycle result pulse; a new start here goes straight to RUN
module chunked_serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  chunked_serial_adder_if.slave bus
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NCH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             last;

  logic [WIDTH-1:0] aop;
  logic [WIDTH-1:0] bop;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_nxt;
  logic             carry;
  logic [KW-1:0]    k;

  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  logic [CHUNK-1:0] a_sl;
  logic [CHUNK-1:0] b_sl;
  logic [CHUNK-1:0] s_sl;
  logic [CHUNK:0]   c;

  assign last = (k == K_LAST);

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        // start is deliberately not looked at here
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Chunk adder: explicit ripple chain so that c[CHUNK-1] (carry into the
  // chunk MSB) is available; on the last chunk that is the carry into the
  // word MSB, used for signed overflow.
  // ---------------------------------------------------------------------
  always_comb begin
    a_sl    = aop[k*CHUNK +: CHUNK];
    b_sl    = bop[k*CHUNK +: CHUNK];
    s_sl    = '0;
    c       = '0;
    c[0]    = carry;
    for (int i = 0; i < CHUNK; i++) begin
      s_sl[i]  = a_sl[i] ^ b_sl[i] ^ c[i];
      c[i + 1] = (a_sl[i] & b_sl[i]) | (c[i] & (a_sl[i] ^ b_sl[i]));
    end
    res_nxt                  = res;
    res_nxt[k*CHUNK +: CHUNK] = s_sl;
  end

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      aop    <= '0;
      bop    <= '0;
      res    <= '0;
      carry  <= 1'b0;
      k      <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      // subtract as A + ~B + ~borrow_in
      aop   <= bus.A;
      bop   <= bus.Sub ? ~bus.B : bus.B;
      carry <= bus.Cin ^ bus.Sub;
      res   <= '0;
      k     <= '0;
    end else if (state == RUN) begin
      res   <= res_nxt;
      carry <= c[CHUNK];
      if (last) begin
        k      <= '0;
        sum_q  <= res_nxt;
        cout_q <= c[CHUNK];
        ovf_q  <= c[CHUNK] ^ c[CHUNK-1];
      end else begin
        k <= k + 1'b1;
      end
    end
  end

  assign bus.Busy     = (state == RUN);
  assign bus.Done     = (state == DONE);
  assign bus.Sum      = sum_q;
  assign bus.Cout     = cout_q;
  assign bus.Overflow = ovf_q;

endmodule

// File: doc/chunked_serial_adder.md
Name: chunked_serial_adder

Overview:
Multi-cycle, parametrised add/subtract unit. It is the sequential successor to the single-bit full-adder cell. Each cycle it adds CHUNK bits of two WIDTH-bit operands through a CHUNK-bit full-adder ripple chain, and keeps the carry in a register between chunks. The block sits in datapaths where area matters more than latency, and uses a start/busy/done handshake toward the controlling FSM.

Parameters:
WIDTH, 16, operand and result width in bits; must be an integer multiple of CHUNK.
CHUNK, 4, bits processed per clock; 1 <= CHUNK <= WIDTH.
NCH (localparam), WIDTH/CHUNK, number of chunk cycles per operation.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
start  input  1  request an operation; sampled on a rising edge of clk.
Sub  input  1  0 = add, 1 = subtract (A - B); sampled with start.
A  input  WIDTH  first operand; sampled with start.
B  input  WIDTH  second operand; sampled with start.
Cin  input  1  carry-in (add) or borrow-in (subtract); sampled with start.
Busy  output  1  high while chunk cycles are in progress.
Done  output  1  one-cycle pulse; Sum, Cout and Overflow become valid on it.
Sum  output  WIDTH  result.
Cout  output  1  carry out of the MSB (add); not-borrow (subtract).
Overflow  output  1  two's-complement signed overflow.

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset, and rst=1 on any edge: state goes to IDLE. Busy=0, Done=0, Sum=0, Cout=0, Overflow=0. Internal operand, carry and chunk-index registers are cleared.
- rst has priority over start.
- States: IDLE, RUN, DONE.
- start is accepted when start=1 on an edge in IDLE or DONE. On acceptance:
  - latch Aop=A and Bop = Sub ? ~B : B;
  - set carry = Cin ^ Sub;
  - set chunk index k=0;
  - go to RUN.
- start=1 while in RUN is ignored. It has no effect on the operation in flight.
- RUN, each cycle:
  - s = Aop[k*CHUNK +: CHUNK] + Bop[k*CHUNK +: CHUNK] + carry;
  - store s into the internal result slice k, and update carry to the chunk carry-out;
  - on the last chunk (k=NCH-1), also capture the carry into the MSB for overflow detection.
  - After NCH RUN cycles, go to DONE.
- On the edge entering DONE:
  - Sum = the full internal result;
  - Cout = final carry;
  - Overflow = carry-into-MSB XOR carry-out-of-MSB.
- Sum, Cout and Overflow are registered. They change only on the DONE-entry edge or on reset, and hold their value until the next completed operation.
- DONE lasts one cycle, then goes to IDLE, unless start is accepted, in which case it goes to RUN.
- Timing for start accepted at edge 0:
  - Busy=1 for cycles 1..NCH;
  - Done=1 in cycle NCH+1;
  - back-to-back throughput is one result every NCH+1 cycles.
- Busy and Done are never high together.
- CHUNK=WIDTH gives NCH=1: one Busy cycle, then Done.
- Subtract semantics: Sub=1 computes Sum = A - B - Cin mod 2^WIDTH. Cout=0 means a borrow occurred.
- Reset during RUN aborts the operation. No Done pulse is produced, and outputs take their reset values.

Test Plan:
1. WIDTH=16/CHUNK=4, add: A=0x1234, B=0x0FCD, Cin=0, start pulse at edge 0 -> Busy high cycles 1-4, Done pulse in cycle 5; Sum=0x2201, Cout=0, Overflow=0.
2. Carry across all chunks and signed overflow:
   - add A=0xFFFF, B=0x0001 -> Sum=0x0000, Cout=1, Overflow=0;
   - add A=0x7FFF, B=0x0001 -> Sum=0x8000, Cout=0, Overflow=1.
3. Subtract:
   - A=0x0005, B=0x0007, Cin=0 -> Sum=0xFFFE, Cout=0, Overflow=0;
   - A=0x8000, B=0x0001 -> Sum=0x7FFF, Cout=1, Overflow=1;
   - A=0x0005, B=0x0002, Cin=1 -> Sum=0x0002, Cout=1.
4. Handshake and throughput:
   - start held high with new operands in cycle 2 of a run -> ignored; the first result is unchanged;
   - start asserted in the DONE cycle (A=0x0001, B=0x0001) -> Busy in the next cycle, second Done exactly 5 cycles after the first, Sum=0x0002.
5. Reset mid-operation: rst=1 in cycle 2 of a run -> next cycle Busy=0, Sum=0, Cout=0, Overflow=0; no Done pulse.
6. Single-cycle instance, WIDTH=8/CHUNK=8: A=0x80, B=0x80, add -> Busy for 1 cycle, Done in cycle 2; Sum=0x00, Cout=1, Overflow=1.
